// File: rtl/mux_bist_seq.sv
// BIST sequencer for the 2:1 mux stage: drives 32 exhaustive patterns,
// checks the returned mux output and reports pass, error count and first failure.
module mux_bist_seq #(
  parameter int WIDTH         = 4,
  parameter int SETTLE_CYCLES = 1,
  parameter int CNT_W         = 6
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] mux_out,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic             s,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_count,
  output logic [4:0]       fail_idx
);

  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SW-1:0] LAST = SW'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

  state_t           state, state_n;
  logic [4:0]       idx, idx_n, idx_inc;
  logic [SW-1:0]    cnt, cnt_n;
  logic [WIDTH-1:0] a_n, b_n, exp_val;
  logic             s_n, busy_n, done_n, miss;
  logic [CNT_W-1:0] err_n;
  logic [4:0]       fail_n;

  // Upper bits are filled so A and B always differ above bit 1.
  function automatic logic [WIDTH-1:0] pat(
    input logic fill, input logic b1, input logic b0);
    logic [WIDTH-1:0] v;
    v    = {WIDTH{fill}};
    v[1] = b1;
    v[0] = b0;
    return v;
  endfunction

  assign idx_inc = idx + 5'd1;
  assign exp_val = s ? B : A;
  assign miss    = (mux_out != exp_val);
  assign pass    = done && (err_count == '0);

  always_comb begin
    state_n = state;
    idx_n   = idx;
    cnt_n   = cnt;
    a_n     = A;
    b_n     = B;
    s_n     = s;
    busy_n  = busy;
    done_n  = done;
    err_n   = err_count;
    fail_n  = fail_idx;
    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          state_n = DRIVE;
          idx_n   = '0;
          cnt_n   = '0;
          err_n   = '0;
          fail_n  = '0;
          a_n     = pat(1'b0, 1'b0, 1'b0);
          b_n     = pat(1'b1, 1'b0, 1'b0);
          s_n     = 1'b0;
          busy_n  = 1'b1;
          done_n  = 1'b0;
        end
      end
      DRIVE: begin
        if (cnt == LAST) begin
          cnt_n   = '0;
          state_n = SAMPLE;
        end else begin
          cnt_n = cnt + SW'(1);
        end
      end
      SAMPLE: begin
        if (miss) begin
          if (err_count != '1) err_n = err_count + CNT_W'(1);
          if (err_count == '0) fail_n = idx;
        end
        if (idx == 5'd31) begin
          state_n = DONE;
          busy_n  = 1'b0;
          done_n  = 1'b1;
          a_n     = '0;
          b_n     = '0;
          s_n     = 1'b0;
        end else begin
          state_n = DRIVE;
          idx_n   = idx_inc;
          a_n     = pat(1'b0, idx_inc[3], idx_inc[1]);
          b_n     = pat(1'b1, idx_inc[4], idx_inc[2]);
          s_n     = idx_inc[0];
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      idx       <= '0;
      cnt       <= '0;
      A         <= '0;
      B         <= '0;
      s         <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err_count <= '0;
      fail_idx  <= '0;
    end else begin
      state     <= state_n;
      idx       <= idx_n;
      cnt       <= cnt_n;
      A         <= a_n;
      B         <= b_n;
      s         <= s_n;
      busy      <= busy_n;
      done      <= done_n;
      err_count <= err_n;
      fail_idx  <= fail_n;
    end
  end

endmodule

// File: tb/tb_mux_bist_seq.sv
// Bench for mux_bist_seq: emulated mux with selectable faults and a
// pattern-level reference model of the expected sequence and results.
module tb_mux_bist_seq;

  localparam int W = 4;
  localparam int P = 2;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         start;
  logic [W-1:0] mux_out;
  logic [W-1:0] A, B;
  logic         s, busy, done, pass;
  logic [5:0]   err_count;
  logic [4:0]   fail_idx;

  int vectors = 0;
  int miscompares = 0;
  int mode = 0;
  bit       flip [32];
  bit [3:0] mask [32];
  logic [4:0] k;

  mux_bist_seq dut (
    .clk(clk), .reset_n(reset_n), .start(start), .mux_out(mux_out),
    .A(A), .B(B), .s(s), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .fail_idx(fail_idx)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] m_a(int i);
    return 4'(((i >> 1) & 1) + 2 * ((i >> 3) & 1));
  endfunction
  function automatic logic [3:0] m_b(int i);
    return 4'(12 + ((i >> 2) & 1) + 2 * ((i >> 4) & 1));
  endfunction
  function automatic logic m_s(int i);
    return 1'(i % 2);
  endfunction

  function automatic logic [3:0] resp(int m, logic sel, logic [3:0] a,
                                      logic [3:0] b, int i);
    logic [3:0] g;
    g = sel ? b : a;
    case (m)
      1: return g & 4'b1110;
      2: return sel ? a : b;
      3: return flip[i] ? (g ^ mask[i]) : g;
      default: return g;
    endcase
  endfunction

  always_comb begin
    k = {B[1], A[1], B[0], A[0], s};
    mux_out = resp(mode, s, A, B, int'(k));
  end

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_pat(string tag, int i);
    check({tag, "_s"}, 32'(s), 32'(m_s(i)));
    check({tag, "_a"}, 32'(A), 32'(m_a(i)));
    check({tag, "_b"}, 32'(B), 32'(m_b(i)));
  endtask

  task automatic run(input int m, input bit hold);
    int exp_err, exp_fail;
    logic [3:0] g;
    exp_err = 0;
    exp_fail = 0;
    for (int i = 0; i < 32; i++) begin
      g = m_s(i) ? m_b(i) : m_a(i);
      if (resp(m, m_s(i), m_a(i), m_b(i), i) != g) begin
        if (exp_err == 0) exp_fail = i;
        exp_err++;
      end
    end
    mode = m;
    start = 1'b1;
    tick();
    if (!hold) start = 1'b0;
    for (int c = 0; c < 32 * P; c++) begin
      check("busy_run", 32'(busy), 1);
      check("done_run", 32'(done), 0);
      check_pat("pat", c / P);
      tick();
    end
    check("busy_end", 32'(busy), 0);
    check("done_end", 32'(done), 1);
    check("err_count", 32'(err_count), 32'(exp_err));
    check("fail_idx", 32'(fail_idx), 32'(exp_fail));
    check("pass", 32'(pass), 32'(exp_err == 0));
    check("abs_idle", 32'({s, A, B}), 0);
  endtask

  initial begin
    reset_n = 1'b0;
    start = 1'b1;
    tick();
    tick();
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_pass", 32'(pass), 0);
    check("rst_err", 32'(err_count), 0);
    check("rst_fail", 32'(fail_idx), 0);
    check("rst_abs", 32'({s, A, B}), 0);
    start = 1'b0;
    reset_n = 1'b1;
    tick();
    tick();
    check("idle_busy", 32'(busy), 0);
    check("idle_abs", 32'({s, A, B}), 0);

    run(0, 1'b0);
    run(1, 1'b0);
    run(2, 1'b0);
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 32; i++) begin
        flip[i] = ($urandom_range(0, 3) == 0);
        mask[i] = 4'($urandom_range(1, 15));
      end
      run(3, 1'b0);
    end

    run(2, 1'b1);
    tick();
    check("rs_busy", 32'(busy), 1);
    check("rs_done", 32'(done), 0);
    check("rs_err", 32'(err_count), 0);
    check("rs_fail", 32'(fail_idx), 0);
    check_pat("rs_pat", 0);
    start = 1'b0;
    repeat (20) tick();
    check_pat("mid_pat", 10);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check("mr_busy", 32'(busy), 0);
    check("mr_done", 32'(done), 0);
    check("mr_err", 32'(err_count), 0);
    check("mr_abs", 32'({s, A, B}), 0);
    tick();
    check("mr_idle", 32'(busy), 0);
    run(0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
